// File: rtl/game_text_sequencer.sv
// Game-state controller and glyph-ROM sequencer for the on-screen word display.
// Runs the attract / playing / game-over machine, maps the beam position onto a
// small text window to address the glyph ROM, and turns the returned row bits
// into a registered text pixel two cycles behind the beam position.
module game_text_sequencer #(
  parameter logic [8:0] TEXT_X        = 9'd64,
  parameter logic [8:0] TEXT_Y        = 9'd96,
  parameter int         ATTRACT_CHARS = 4,
  parameter int         OVER_CHARS    = 9,
  parameter int         BLINK_FRAMES  = 32,
  parameter int         OVER_FRAMES   = 180
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [8:0] hpos_i,
  input  logic [8:0] vpos_i,
  input  logic       display_on_i,
  input  logic       start_btn_i,
  input  logic       player_dead_i,
  input  logic [4:0] rom_bits_i,
  output logic [3:0] glyph_index_o,
  output logic [2:0] glyph_row_o,
  output logic       text_pixel_o,
  output logic [1:0] game_state_o,
  output logic       playing_o
);

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2,
    ST_UNUSED  = 2'd3
  } state_e;

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int OW = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [OW-1:0] OVER_LAST  = OW'(OVER_FRAMES - 1);
  localparam logic [4:0]    ATTRACT_N  = 5'(ATTRACT_CHARS);
  localparam logic [4:0]    OVER_N     = 5'(OVER_CHARS);

  state_e          state_q, state_d;
  logic            start_prev_q;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_on_q, blink_on_d;
  logic [OW-1:0]   over_cnt_q, over_cnt_d;

  logic [3:0]      glyph_index_q, glyph_index_d;
  logic [2:0]      glyph_row_q, glyph_row_d;
  logic [2:0]      col_q, col_d;
  logic            win_q, win_d;
  logic            text_pixel_q, text_pixel_d;

  logic            frame_tick;
  logic            start_rise;
  logic            blink_eff;
  logic [8:0]      relx, rely;
  logic [4:0]      nchars;
  logic            rom_bit;

  assign frame_tick = (hpos_i == 9'd0) && (vpos_i == 9'd0);
  assign start_rise = start_btn_i & ~start_prev_q;
  assign blink_eff  = blink_on_q | (state_q != ST_ATTRACT);

  // Next state and frame counters: blink timer runs only in attract, dwell timer only in game-over
  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    over_cnt_d  = over_cnt_q;
    case (state_q)
      ST_ATTRACT: begin
        if (start_rise) begin
          state_d     = ST_PLAYING;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end else if (frame_tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      ST_PLAYING: begin
        if (player_dead_i) begin
          state_d    = ST_OVER;
          over_cnt_d = '0;
        end
      end
      ST_OVER: begin
        if (frame_tick) begin
          if (over_cnt_q == OVER_LAST) begin
            state_d     = ST_ATTRACT;
            over_cnt_d  = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
          end else begin
            over_cnt_d = over_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_ATTRACT;
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
      end
    endcase
  end

  // Stage 1: window test and ROM address; wrapped (negative) offsets are excluded by the >= tests
  always_comb begin
    relx = hpos_i - TEXT_X;
    rely = vpos_i - TEXT_Y;
    case (state_q)
      ST_ATTRACT: nchars = ATTRACT_N;
      ST_OVER:    nchars = OVER_N;
      default:    nchars = 5'd0;
    endcase
    win_d = (hpos_i >= TEXT_X) && (vpos_i >= TEXT_Y) && (rely < 9'd10) &&
            (relx[8:4] < nchars) && display_on_i;
    glyph_index_d = win_d ? relx[7:4] : 4'hF;
    glyph_row_d   = win_d ? rely[3:1] : 3'd0;
    col_d         = relx[3:1];
  end

  // Stage 2: pick the ROM bit for the column (MSB is leftmost; columns 5..7 are blank gap)
  always_comb begin
    rom_bit = 1'b0;
    case (col_q)
      3'd0:    rom_bit = rom_bits_i[4];
      3'd1:    rom_bit = rom_bits_i[3];
      3'd2:    rom_bit = rom_bits_i[2];
      3'd3:    rom_bit = rom_bits_i[1];
      3'd4:    rom_bit = rom_bits_i[0];
      default: rom_bit = 1'b0;
    endcase
    text_pixel_d = win_q & blink_eff & rom_bit;
  end

  // State, counters and both pipeline stages, cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_ATTRACT;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      over_cnt_q    <= '0;
      glyph_index_q <= 4'hF;
      glyph_row_q   <= 3'd0;
      col_q         <= 3'd0;
      win_q         <= 1'b0;
      text_pixel_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      over_cnt_q    <= over_cnt_d;
      glyph_index_q <= glyph_index_d;
      glyph_row_q   <= glyph_row_d;
      col_q         <= col_d;
      win_q         <= win_d;
      text_pixel_q  <= text_pixel_d;
    end
  end

  // Button history tracks the pin even through reset, so a button held across reset is not a press
  always_ff @(posedge clk_i) begin
    start_prev_q <= start_btn_i;
  end

  assign glyph_index_o = glyph_index_q;
  assign glyph_row_o   = glyph_row_q;
  assign text_pixel_o  = text_pixel_q;
  assign game_state_o  = state_q;
  assign playing_o     = (state_q == ST_PLAYING);

endmodule

// File: tb/tb_game_text_sequencer.sv
// Bench for game_text_sequencer: directed vector table, a hand-written latency
// sequence and randomized traffic compared against a frame-level reference model.
module tb_game_text_sequencer;

  localparam int BLINK = 2;
  localparam int OVERF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [8:0] hpos, vpos;
  logic       displayOn, startBtn, playerDead;
  logic [4:0] romBits, ovRom;
  logic       useOv;
  logic [3:0] glyphIndex;
  logic [2:0] glyphRow;
  logic       textPixel;
  logic [1:0] gameState;
  logic       playing;

  int passCnt = 0;
  int totalCnt = 0;

  typedef struct {
    bit         rst;
    int         h;
    int         v;
    bit         disp;
    int         st;
    bit         blink;
    logic [4:0] rom;
  } rec_t;

  typedef struct {
    bit         rst;
    int         h;
    int         v;
    bit         disp;
    bit         start;
    bit         dead;
    logic [4:0] rom;
    int         cycles;
    bit         chkVid;
    int         st;
    int         g;
    int         r;
    bit         p;
    string      name;
  } vec_t;

  rec_t prevRec;
  int   mState, mAttractTicks, mOverTicks;
  bit   mPrev;
  int   expState, expGlyph, expRow;
  bit   expPix;
  vec_t vecs[$];

  game_text_sequencer #(
    .TEXT_X(9'd64), .TEXT_Y(9'd96), .ATTRACT_CHARS(4), .OVER_CHARS(9),
    .BLINK_FRAMES(BLINK), .OVER_FRAMES(OVERF)
  ) dut (
    .clk_i(clk), .reset_i(reset), .hpos_i(hpos), .vpos_i(vpos),
    .display_on_i(displayOn), .start_btn_i(startBtn), .player_dead_i(playerDead),
    .rom_bits_i(romBits), .glyph_index_o(glyphIndex), .glyph_row_o(glyphRow),
    .text_pixel_o(textPixel), .game_state_o(gameState), .playing_o(playing)
  );

  // Stand-in glyph ROM: arbitrary but deterministic row pattern per glyph/row
  function automatic logic [4:0] romFn(input logic [3:0] g, input logic [2:0] r);
    logic [7:0] t;
    t = {g, 1'b0, r} * 8'd37 + 8'd13;
    return t[6:2];
  endfunction

  assign romBits = useOv ? ovRom : romFn(glyphIndex, glyphRow);

  // Whether a beam position falls on a displayed glyph cell in the given state
  function automatic bit inWin(input rec_t r);
    int n;
    n = (r.st == 0) ? 4 : ((r.st == 2) ? 9 : 0);
    if (r.rst || !r.disp || r.h < 64 || r.v < 96) return 1'b0;
    return ((r.v - 96) < 10) && (((r.h - 64) / 16) < n);
  endfunction

  function automatic bit blinkNow();
    return (mState != 0) || (((mAttractTicks / BLINK) % 2) == 0);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One clock cycle: drive inputs, advance the reference model, compare all outputs
  task automatic applyStimulus(input bit rst, input int h, input int v, input bit disp,
                               input bit start, input bit dead, input logic [4:0] rom,
                               input string tag);
    rec_t cur;
    int   g, r, col;
    bit   tick, rise;
    @(negedge clk);
    reset = rst; hpos = 9'(h); vpos = 9'(v); displayOn = disp;
    startBtn = start; playerDead = dead; ovRom = rom;
    cur.rst = rst; cur.h = h; cur.v = v; cur.disp = disp;
    cur.st = mState; cur.blink = blinkNow();
    if (inWin(prevRec)) begin
      g = (prevRec.h - 64) / 16; r = (prevRec.v - 96) / 2;
    end else begin
      g = 15; r = 0;
    end
    cur.rom = useOv ? rom : romFn(4'(g), 3'(r));
    expPix = 1'b0;
    if (!rst && inWin(prevRec)) begin
      col = ((prevRec.h - 64) % 16) / 2;
      if (col < 5) expPix = cur.blink && cur.rom[4 - col];
    end
    if (inWin(cur)) begin
      expGlyph = (h - 64) / 16; expRow = (v - 96) / 2;
    end else begin
      expGlyph = 15; expRow = 0;
    end
    tick = (h == 0) && (v == 0);
    rise = start && !mPrev;
    mPrev = start;
    if (rst) begin
      mState = 0; mAttractTicks = 0; mOverTicks = 0;
    end else if (mState == 0) begin
      if (rise) begin mState = 1; mAttractTicks = 0; end
      else if (tick) mAttractTicks++;
    end else if (mState == 1) begin
      if (dead) begin mState = 2; mOverTicks = 0; end
    end else if (tick) begin
      mOverTicks++;
      if (mOverTicks == OVERF) begin mState = 0; mAttractTicks = 0; end
    end
    expState = mState;
    @(posedge clk);
    #2;
    checkOutput({tag, ":state"}, int'(gameState), expState);
    checkOutput({tag, ":playing"}, int'(playing), int'(expState == 1));
    checkOutput({tag, ":glyph"}, int'(glyphIndex), expGlyph);
    checkOutput({tag, ":row"}, int'(glyphRow), expRow);
    checkOutput({tag, ":pixel"}, int'(textPixel), int'(expPix));
    prevRec = cur;
  endtask

  initial begin
    reset = 1'b1; hpos = 9'd300; vpos = 9'd300; displayOn = 1'b1;
    startBtn = 1'b0; playerDead = 1'b0; ovRom = 5'd0; useOv = 1'b1;
    prevRec = '{rst: 1'b1, h: 300, v: 300, disp: 1'b1, st: 0, blink: 1'b1, rom: 5'd0};
    mState = 0; mAttractTicks = 0; mOverTicks = 0; mPrev = 1'b0;

    // rst h v disp start dead rom cycles chkVid | st glyph row pix | name
    vecs = '{
      '{1, 300, 300, 1, 1, 0, 5'h00, 3, 1, 0, 15, 0, 0, "reset"},
      '{0, 300, 300, 1, 1, 0, 5'h00, 2, 1, 0, 15, 0, 0, "held_start"},
      '{0,  64,  96, 1, 0, 0, 5'h1F, 3, 1, 0,  0, 0, 1, "attract_px"},
      '{0, 128,  96, 1, 0, 0, 5'h1F, 3, 1, 0, 15, 0, 0, "slot4"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 0,  0, 0, 0, "tick1"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 0,  0, 0, 0, "tick2"},
      '{0,  64,  96, 1, 0, 0, 5'h1F, 3, 1, 0,  0, 0, 0, "blink_off"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 0,  0, 0, 0, "tick3"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 0,  0, 0, 0, "tick4"},
      '{0,  64,  96, 1, 0, 0, 5'h1F, 3, 1, 0,  0, 0, 1, "blink_on"},
      '{0,  74,  96, 1, 0, 0, 5'h1F, 3, 1, 0,  0, 0, 0, "col5"},
      '{0,  66,  96, 1, 0, 0, 5'h08, 3, 1, 0,  0, 0, 1, "col1_on"},
      '{0,  66,  96, 1, 0, 0, 5'h17, 3, 1, 0,  0, 0, 0, "col1_off"},
      '{0,  63,  96, 1, 0, 0, 5'h1F, 3, 1, 0, 15, 0, 0, "left_edge"},
      '{0,  64, 105, 1, 0, 0, 5'h1F, 3, 1, 0,  0, 4, 1, "row4"},
      '{0,  64, 106, 1, 0, 0, 5'h1F, 3, 1, 0, 15, 0, 0, "below"},
      '{0, 127,  96, 1, 0, 0, 5'h1F, 3, 1, 0,  3, 0, 0, "slot3_col7"},
      '{0,  64,  96, 0, 0, 0, 5'h1F, 3, 1, 0, 15, 0, 0, "disp_off"},
      '{0, 300, 300, 1, 1, 0, 5'h1F, 1, 1, 1, 15, 0, 0, "start"},
      '{0,  64,  96, 1, 0, 0, 5'h1F, 3, 1, 1, 15, 0, 0, "playing_dark"},
      '{0, 300, 300, 1, 1, 1, 5'h1F, 1, 1, 2, 15, 0, 0, "dead_and_start"},
      '{0, 192,  98, 1, 0, 0, 5'h1F, 3, 1, 2,  8, 1, 1, "over_slot8"},
      '{0, 208,  98, 1, 0, 0, 5'h1F, 3, 1, 2, 15, 0, 0, "over_slot9"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 2,  0, 0, 0, "otick1"},
      '{0, 300, 300, 1, 1, 0, 5'h1F, 1, 0, 2,  0, 0, 0, "over_start"},
      '{0, 300, 300, 1, 0, 0, 5'h1F, 1, 0, 2,  0, 0, 0, "over_release"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 2,  0, 0, 0, "otick2"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 0,  0, 0, 0, "otick3"},
      '{0, 300, 300, 1, 1, 0, 5'h1F, 1, 0, 1,  0, 0, 0, "start2"},
      '{0, 300, 300, 1, 0, 1, 5'h1F, 1, 0, 2,  0, 0, 0, "dead2"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 2,  0, 0, 0, "otick_a"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 2,  0, 0, 0, "otick_b"},
      '{1, 300, 300, 1, 0, 0, 5'h1F, 1, 1, 0, 15, 0, 0, "mid_reset"},
      '{0, 300, 300, 1, 1, 0, 5'h1F, 1, 0, 1,  0, 0, 0, "start3"},
      '{0, 300, 300, 1, 0, 1, 5'h1F, 1, 0, 2,  0, 0, 0, "dead3"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 2,  0, 0, 0, "dwell_1"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 2,  0, 0, 0, "dwell_2"},
      '{0,   0,   0, 1, 0, 0, 5'h1F, 1, 0, 0,  0, 0, 0, "dwell_3"},
      '{0,  64,  96, 1, 0, 0, 5'h1F, 3, 1, 0,  0, 0, 1, "attract_again"}
    };

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].cycles; c++)
        applyStimulus(vecs[i].rst, vecs[i].h, vecs[i].v, vecs[i].disp,
                      vecs[i].start, vecs[i].dead, vecs[i].rom, vecs[i].name);
      checkOutput({vecs[i].name, ":tbl_state"}, int'(gameState), vecs[i].st);
      checkOutput({vecs[i].name, ":tbl_playing"}, int'(playing), int'(vecs[i].st == 1));
      if (vecs[i].chkVid) begin
        checkOutput({vecs[i].name, ":tbl_glyph"}, int'(glyphIndex), vecs[i].g);
        checkOutput({vecs[i].name, ":tbl_row"}, int'(glyphRow), vecs[i].r);
        checkOutput({vecs[i].name, ":tbl_pixel"}, int'(textPixel), int'(vecs[i].p));
      end
    end

    // Latency: one lit pixel cycle must surface on text_pixel exactly two edges later
    applyStimulus(1'b0, 300, 300, 1'b1, 1'b0, 1'b0, 5'h1F, "lat_idle");
    applyStimulus(1'b0, 64, 96, 1'b1, 1'b0, 1'b0, 5'h1F, "lat_a");
    checkOutput("lat_a_glyph", int'(glyphIndex), 0);
    checkOutput("lat_a_pixel", int'(textPixel), 0);
    applyStimulus(1'b0, 300, 300, 1'b1, 1'b0, 1'b0, 5'h1F, "lat_b");
    checkOutput("lat_b_glyph", int'(glyphIndex), 15);
    checkOutput("lat_b_pixel", int'(textPixel), 1);
    applyStimulus(1'b0, 300, 300, 1'b1, 1'b0, 1'b0, 5'h1F, "lat_c");
    checkOutput("lat_c_pixel", int'(textPixel), 0);

    // Randomized traffic with the stand-in ROM in the loop
    useOv = 1'b0;
    applyStimulus(1'b1, 300, 300, 1'b1, 1'b0, 1'b0, 5'h00, "rnd_rst");
    applyStimulus(1'b1, 300, 300, 1'b1, 1'b0, 1'b0, 5'h00, "rnd_rst");
    for (int n = 0; n < 3000; n++) begin
      bit rr, ss, dd, ds;
      int hh, vv;
      rr = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) begin
        hh = 0; vv = 0;
      end else begin
        hh = int'($urandom_range(40, 250));
        vv = int'($urandom_range(90, 112));
      end
      ss = ($urandom_range(0, 7) == 0);
      dd = ($urandom_range(0, 14) == 0);
      ds = ($urandom_range(0, 9) != 0);
      applyStimulus(rr, hh, vv, ds, ss, dd, 5'h00, "rnd");
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
